whack_game_ctrl: RTL
====================

// Module: whack_game_ctrl
// PURPOSE
//   Game sequencer for Whack-a-Mole: owns the game FSM, mole placement/lifetime, hit detection,
//   score and countdown. Drives the mole LEDs; score/time_left feed the BCD/7-seg display path.
//   A 1 Hz single-cycle tick enable paces the countdown; the mole lifetime is counted in clk cycles.
// PARAMETERS
//   GAME_SECONDS  20          countdown start value (1..31)
//   MOLE_CYCLES   75_000_000  clk cycles a mole stays lit before timing out (>=2)
//   GAP_CYCLES    25_000_000  clk cycles all LEDs dark between moles (>=1)
//   SCORE_MAX     63          score saturation value (<=63)
//   LFSR_SEED     16'hACE1    LFSR value loaded at reset (nonzero)
// PORTS
//   clk        in   1   system clock, 100 MHz
//   reset      in   1   asynchronous, active-low reset
//   tick_1hz   in   1   one-clk-wide enable, once per second
//   start      in   1   start button level, asynchronous to clk
//   sw         in   16  whack switches, asynchronous to clk
//   led        out  16  one-hot mole (all zero when no mole lit)
//   score      out  6   hits this game
//   time_left  out  5   seconds remaining
//   playing    out  1   high in GAP/MOLE
//   game_over  out  1   high in OVER
// BEHAVIOUR
//   - Single clock; reset=0 asynchronously forces: state=IDLE, led=0, score=0,
//     time_left=GAME_SECONDS, playing=0, game_over=0, LFSR=LFSR_SEED, counters=0, sync flops=0.
//   - start and sw pass through 2-FF synchronizers. start_rise = rising edge of synced start.
//     sw_evt[i] = synced sw[i] differs from its previous synced value (toggle in either direction).
//   - 16-bit Fibonacci LFSR (taps 16,14,13,11) advances every clk in all states; mole index =
//     LFSR[3:0]; if index equals the previous mole index, use index+1 (mod 16) -> no repeats.
//   - States: IDLE, GAP, MOLE, OVER.
//     IDLE: led=0. start_rise -> GAP; score<=0, time_left<=GAME_SECONDS, gap counter cleared.
//     GAP : led=0; count GAP_CYCLES, then -> MOLE; led<=one-hot(index), life counter cleared.
//     MOLE: led one-hot. sw_evt on lit bit = HIT: score<=min(score+1,SCORE_MAX), led<=0 -> GAP.
//           life counter reaches MOLE_CYCLES-1 without hit = MISS -> GAP, no score change.
//           sw_evt on unlit bits ignored (no penalty). Hit and timeout same cycle: HIT wins.
//     OVER: led=0, game_over=1, score and time_left hold. start_rise -> GAP (new game, as IDLE).
//   - Countdown: in GAP/MOLE each tick_1hz decrements time_left; when time_left==1 and tick_1hz,
//     time_left<=0 and state -> OVER next cycle. tick_1hz ignored in IDLE/OVER.
//   - HIT and final tick in same cycle: score increments, then OVER (hit counted).
//   - start_rise during GAP/MOLE ignored. Multiple sw_evt in one cycle: only lit bit matters.
//   - All outputs registered; HIT visible on led/score 1 clk after the synced edge
//     (3 clk after sw pin change). Mid-game reset aborts immediately to reset values.
// STRUCTURE
//   - Shared header whack_pkg.vh: state encodings (IDLE=2'd0,GAP=2'd1,MOLE=2'd2,OVER=2'd3),
//     LFSR tap mask, default GAME_SECONDS/SCORE_MAX; also used by display/timer blocks.
//   - Sub-module lfsr16 (clk, reset, seed param, q[15:0]); rest (sync, edge detect, FSM,
//     counters, score/time regs) in this module. Counter widths via $clog2 of cycle params.
// TESTING  (sim: MOLE_CYCLES=20, GAP_CYCLES=5, GAME_SECONDS=3, tick_1hz driven by bench)
//   1 reset low mid-MOLE -> led=0, score=0, time_left=3, playing=0 same cycle, async.
//   2 start pulse, wait 5 clk -> exactly one led bit set; toggle that sw -> 3 clk later score=1,
//     led=0; next mole index differs from previous.
//   3 toggle an unlit sw during MOLE -> score unchanged; no toggle for 20 clk -> led=0, score unchanged.
//   4 three tick_1hz pulses during play -> time_left 3,2,1,0; game_over=1, led=0, further sw
//     toggles and ticks leave score/time_left unchanged.
//   5 synced hit on same cycle as final tick -> score increments and game_over=1; hit on same
//     cycle as mole timeout -> score increments.
//   6 preload score path with 64 hits (SCORE_MAX=63, long GAME_SECONDS) -> score holds at 63;
//     start in OVER -> score=0, time_left=GAME_SECONDS, playing=1.

Source files
------------

// File: rtl/whack_pkg.sv
// Shared whack-a-mole definitions: FSM state encodings, LFSR taps,
// default game constants and the no-repeat mole index helper.
package whack_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GAP  = 2'd1,
        MOLE = 2'd2,
        OVER = 2'd3
    } state_t;

    // Fibonacci taps 16,14,13,11 -> bits 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam int DEF_GAME_SECONDS = 20;
    localparam int DEF_SCORE_MAX    = 63;

    // Bump the raw index by one when it would repeat the last mole
    function automatic logic [3:0] pick_idx(
        input logic [3:0] raw,
        input logic [3:0] prev
    );
        return (raw == prev) ? raw + 4'd1 : raw;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR, free running every clk.
// Ports: clk, reset (async active-low, loads SEED), q[15:0] state.
module lfsr16
    import whack_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) q <= SEED;
        else        q <= {q[14:0], ^(q & LFSR_TAPS)};
    end

endmodule

// File: rtl/whack_game_ctrl.sv
// Whack-a-mole game sequencer: FSM, mole placement/lifetime, hits, score, countdown.
// Ports: clk, reset (async low), tick_1hz, start, sw[15:0] in; led, score, time_left, playing, game_over out.
module whack_game_ctrl
    import whack_pkg::*;
#(
    parameter int          GAME_SECONDS = DEF_GAME_SECONDS,
    parameter int          MOLE_CYCLES  = 75_000_000,
    parameter int          GAP_CYCLES   = 25_000_000,
    parameter int          SCORE_MAX    = DEF_SCORE_MAX,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick_1hz,
    input  logic        start,
    input  logic [15:0] sw,
    output logic [15:0] led,
    output logic [5:0]  score,
    output logic [4:0]  time_left,
    output logic        playing,
    output logic        game_over
);

    localparam int LW = (MOLE_CYCLES > 1) ? $clog2(MOLE_CYCLES) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [LW-1:0] LIFE_LAST = LW'(MOLE_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);
    localparam logic [4:0]    SECS      = 5'(GAME_SECONDS);
    localparam logic [5:0]    SMAX      = 6'(SCORE_MAX);

    state_t state, state_n;

    logic [15:0]   led_n;
    logic [5:0]    score_n;
    logic [4:0]    time_n;
    logic          playing_n;
    logic          over_n;
    logic [GW-1:0] gap_cnt, gap_n;
    logic [LW-1:0] life_cnt, life_n;
    logic [3:0]    prev_idx, prev_n;

    logic          st_s1, st_s2, st_q;
    logic [15:0]   sw_s1, sw_s2, sw_q;
    logic          start_rise;
    logic [15:0]   sw_evt;
    logic          hit;
    logic [3:0]    idx;

    logic [15:0]   lfsr_q;
    logic          lfsr_unused;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .q     (lfsr_q)
    );

    assign lfsr_unused = ^lfsr_q[15:4];

    // 2-FF synchronizers plus one history stage for edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_s1 <= 1'b0;
            st_s2 <= 1'b0;
            st_q  <= 1'b0;
            sw_s1 <= '0;
            sw_s2 <= '0;
            sw_q  <= '0;
        end else begin
            st_s1 <= start;
            st_s2 <= st_s1;
            st_q  <= st_s2;
            sw_s1 <= sw;
            sw_s2 <= sw_s1;
            sw_q  <= sw_s2;
        end
    end

    assign start_rise = st_s2 & ~st_q;
    assign sw_evt     = sw_s2 ^ sw_q;
    // led only has the lit bit set in MOLE, so unlit toggles drop out here
    assign hit        = |(sw_evt & led);
    assign idx        = pick_idx(lfsr_q[3:0], prev_idx);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            led       <= '0;
            score     <= '0;
            time_left <= SECS;
            playing   <= 1'b0;
            game_over <= 1'b0;
            gap_cnt   <= '0;
            life_cnt  <= '0;
            prev_idx  <= '0;
        end else begin
            state     <= state_n;
            led       <= led_n;
            score     <= score_n;
            time_left <= time_n;
            playing   <= playing_n;
            game_over <= over_n;
            gap_cnt   <= gap_n;
            life_cnt  <= life_n;
            prev_idx  <= prev_n;
        end
    end

    always_comb begin
        state_n = state;
        led_n   = led;
        score_n = score;
        time_n  = time_left;
        gap_n   = gap_cnt;
        life_n  = life_cnt;
        prev_n  = prev_idx;

        unique case (state)
            IDLE, OVER: begin
                led_n = '0;
                if (start_rise) begin
                    state_n = GAP;
                    score_n = '0;
                    time_n  = SECS;
                    gap_n   = '0;
                end
            end
            GAP: begin
                led_n = '0;
                if (gap_cnt == GAP_LAST) begin
                    state_n = MOLE;
                    led_n   = 16'd1 << idx;
                    prev_n  = idx;
                    life_n  = '0;
                end else begin
                    gap_n = gap_cnt + 1'b1;
                end
            end
            MOLE: begin
                // hit is checked first so it wins over a same-cycle timeout
                if (hit) begin
                    score_n = (score >= SMAX) ? SMAX : score + 6'd1;
                    led_n   = '0;
                    state_n = GAP;
                    gap_n   = '0;
                end else if (life_cnt == LIFE_LAST) begin
                    led_n   = '0;
                    state_n = GAP;
                    gap_n   = '0;
                end else begin
                    life_n = life_cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                led_n   = '0;
            end
        endcase

        // Countdown overrides the mole transitions but keeps any score update
        if ((state == GAP || state == MOLE) && tick_1hz) begin
            if (time_left > 5'd1) begin
                time_n = time_left - 5'd1;
            end else begin
                time_n  = '0;
                state_n = OVER;
                led_n   = '0;
            end
        end

        playing_n = (state_n == GAP) || (state_n == MOLE);
        over_n    = (state_n == OVER);
    end

endmodule
